// File: rtl/llr_loader.sv
// Collects a stream of signed LLR samples into one flat frame word for the decoder core.
// Optional input saturation to +/-(2^(data_w-1)-1) is enabled by defining LLR_SAT_EN.
module llr_loader #(
    parameter int unsigned data_w = 12,
    parameter int unsigned R      = 24,
    parameter int unsigned D      = 24,
    parameter int unsigned in_w   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [in_w-1:0]          in_llr,
    input  logic                     in_last,
    output logic [R*D*data_w-1:0]    l,
    output logic                     frame_valid,
    input  logic                     frame_ack,
    output logic                     frame_err
);

    localparam int unsigned N     = R * D;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_slot;
    logic                r_in_ready;
    logic                r_frame_valid;
    logic                r_frame_err;
    logic [N*data_w-1:0] r_l;
    logic                w_accept;
    logic                w_at_end;
    logic                w_err;
    logic                w_ready_nxt;
    logic                w_valid_nxt;
    logic [data_w-1:0]   w_word;

    assign in_ready    = r_in_ready;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign l           = r_l;

    assign w_accept = in_valid & r_in_ready;
    assign w_at_end = (r_cnt == CNT_W'(N - 1));
    // Sample k lands in word N-1-k so that sample 0 sits in the MSBs.
    assign w_slot   = CNT_W'(N - 1) - r_cnt;

`ifdef LLR_SAT_EN
    localparam int SAT_MAX = (2 ** (data_w - 1)) - 1;
    localparam logic signed [in_w-1:0] SAT_HI = in_w'(SAT_MAX);
    localparam logic signed [in_w-1:0] SAT_LO = in_w'(-SAT_MAX);

    logic signed [in_w-1:0] w_llr_s;
    assign w_llr_s = $signed(in_llr);

    // Symmetric clamp: the most negative code is folded onto -SAT_MAX.
    always_comb begin
        w_word = w_llr_s[data_w-1:0];
        if (w_llr_s > SAT_HI) begin
            w_word = data_w'(SAT_MAX);
        end else if (w_llr_s < SAT_LO) begin
            w_word = data_w'(-SAT_MAX);
        end
    end
`else
    logic w_unused_llr;
    assign w_unused_llr = ^in_llr;
    assign w_word       = in_llr[data_w-1:0];
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and framing-error decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err       = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    if (w_at_end && in_last) begin
                        w_state_nxt = S_FULL;
                        w_cnt_nxt   = '0;
                    end else if (w_at_end || in_last) begin
                        w_err     = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_FULL: begin
                if (frame_ack) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode, registered below so the flags track the state they describe.
    always_comb begin
        w_ready_nxt = (w_state_nxt == S_FILL);
        w_valid_nxt = (w_state_nxt == S_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready    <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_in_ready    <= w_ready_nxt;
            r_frame_valid <= w_valid_nxt;
            r_frame_err   <= w_err;
        end
    end

    // Frame store: only written on accepted samples, so it holds still while FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_l <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (w_accept && (w_slot == CNT_W'(i))) begin
                    r_l[i*data_w +: data_w] <= w_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_llr_loader.sv
// Directed bench for llr_loader: framing, hold/ack handshake, errors, reset and saturation.
module tb_llr_loader;

    localparam int unsigned DW = 12;
    localparam int unsigned R  = 24;
    localparam int unsigned D  = 24;
    localparam int unsigned IW = 16;
    localparam int unsigned N  = R * D;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IW-1:0]     in_llr;
    logic              in_last;
    logic [N*DW-1:0]   l;
    logic              frame_valid;
    logic              frame_ack;
    logic              frame_err;

    logic [N*DW-1:0]   exp_l;
    logic [N*DW-1:0]   snap_l;
    logic [IW-1:0]     sat_vals [3];

    int checks = 0;
    int errors = 0;
    int pulses;

    llr_loader #(.data_w(DW), .R(R), .D(D), .in_w(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_llr      (in_llr),
        .in_last     (in_last),
        .l           (l),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] val(input int k);
        return IW'((k % 201) - 100);
    endfunction

    function automatic logic [DW-1:0] exp_word(input logic [IW-1:0] x);
        logic signed [IW-1:0] s;
        s = $signed(x);
`ifdef LLR_SAT_EN
        if (s > 16'sd2047)  return 12'h7FF;
        if (s < -16'sd2047) return 12'h801;
`endif
        return s[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_l(input string tag, input logic [N*DW-1:0] expv);
        checks++;
        assert (l === expv) else begin
            errors++;
            $error("FAIL %s observed_hi=%h observed_lo=%h expected_hi=%h expected_lo=%h",
                   tag, l[N*DW-1 -: 64], l[63:0], expv[N*DW-1 -: 64], expv[63:0]);
        end
    endtask

    // Drives samples 0..n_send-1 at negedges; returns with one negedge past the last accept.
    task automatic send_frame(input int n_send, input int last_pos, input bit gaps,
                              input bit sat, output int npulse);
        int k;
        int cyc;
        k      = 0;
        cyc    = 0;
        npulse = 0;
        while (k < n_send && cyc < 20000) begin
            @(negedge clk);
            if (frame_err === 1'b1) npulse++;
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_llr   = (sat && k < 3) ? sat_vals[k] : val(k);
            in_last  = (k == last_pos);
            if (in_valid && in_ready) begin
                exp_l[(N-1-k)*DW +: DW] = exp_word(in_llr);
                k++;
            end
            cyc++;
        end
        chk("fill_timeout", 32'(k < n_send), 32'd0);
        @(negedge clk);
        if (frame_err === 1'b1) npulse++;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic ack_frame();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk("ack_ready", 32'(in_ready), 32'd1);
        chk("ack_valid_low", 32'(frame_valid), 32'd0);
    endtask

    initial begin
        sat_vals[0] = IW'(3000);
        sat_vals[1] = IW'(-3000);
        sat_vals[2] = IW'(-2048);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_llr    = '0;
        in_last   = 1'b0;
        frame_ack = 1'b0;
        exp_l     = '0;

        // Reset values before any clock edge.
        #1;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk_l("rst_l", exp_l);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("post_rst_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("post_rst_ready_high", 32'(in_ready), 32'd1);

        // Gap-free reference frame.
        send_frame(N, N - 1, 1'b0, 1'b0, pulses);
        chk("f1_valid", 32'(frame_valid), 32'd1);
        chk("f1_ready", 32'(in_ready), 32'd0);
        chk("f1_err_pulses", 32'(pulses), 32'd0);
        chk_l("f1_l", exp_l);
        chk("f1_msb_word", 32'(l[N*DW-1 -: DW]), 32'h0F9C);
        chk("f1_lsb_word", 32'(l[DW-1:0]), 32'h0049);
        snap_l = l;

        // FULL holds off new input and keeps l stable until acknowledged.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(frame_valid), 32'd1);
            chk_l("hold_l", snap_l);
            in_valid = 1'b1;
            in_llr   = IW'(i * 37);
            in_last  = i[0];
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk("ack1_ready", 32'(in_ready), 32'd1);
        chk("ack1_valid_low", 32'(frame_valid), 32'd0);

        // Early in_last on sample 100.
        send_frame(101, 100, 1'b0, 1'b0, pulses);
        chk("early_err_hi", 32'(frame_err), 32'd1);
        chk("early_valid", 32'(frame_valid), 32'd0);
        @(negedge clk);
        chk("early_err_one_cycle", 32'(frame_err), 32'd0);
        chk("early_ready", 32'(in_ready), 32'd1);
        send_frame(N, N - 1, 1'b0, 1'b0, pulses);
        chk("after_early_valid", 32'(frame_valid), 32'd1);
        chk("after_early_pulses", 32'(pulses), 32'd0);
        chk_l("after_early_l", exp_l);
        ack_frame();

        // Missing in_last on sample N-1.
        send_frame(N, -1, 1'b0, 1'b0, pulses);
        chk("nolast_err_hi", 32'(frame_err), 32'd1);
        chk("nolast_valid", 32'(frame_valid), 32'd0);
        chk("nolast_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("nolast_err_one_cycle", 32'(frame_err), 32'd0);

        // Out-of-range samples at the head of a frame.
        send_frame(N, N - 1, 1'b0, 1'b1, pulses);
        chk("sat_valid", 32'(frame_valid), 32'd1);
        chk_l("sat_l", exp_l);
`ifdef LLR_SAT_EN
        chk("sat_w0", 32'(l[N*DW-1 -: DW]), 32'h07FF);
        chk("sat_w1", 32'(l[(N-1)*DW-1 -: DW]), 32'h0801);
        chk("sat_w2", 32'(l[(N-2)*DW-1 -: DW]), 32'h0801);
`else
        chk("wrap_w0", 32'(l[N*DW-1 -: DW]), 32'h0BB8);
        chk("wrap_w1", 32'(l[(N-1)*DW-1 -: DW]), 32'h0448);
        chk("wrap_w2", 32'(l[(N-2)*DW-1 -: DW]), 32'h0800);
`endif
        chk("inrange_w3", 32'(l[(N-3)*DW-1 -: DW]), 32'h0F9F);
        ack_frame();

        // Reset in the middle of a frame.
        send_frame(300, -1, 1'b0, 1'b0, pulses);
        rst = 1'b1;
        #1;
        exp_l = '0;
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_valid", 32'(frame_valid), 32'd0);
        chk("midrst_err", 32'(frame_err), 32'd0);
        chk_l("midrst_l", exp_l);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_back", 32'(in_ready), 32'd1);
        send_frame(N, N - 1, 1'b0, 1'b0, pulses);
        chk("midrst_frame_valid", 32'(frame_valid), 32'd1);
        chk("midrst_frame_pulses", 32'(pulses), 32'd0);
        chk_l("midrst_frame_l", exp_l);
        ack_frame();

        // Randomly gapped in_valid yields the same frame.
        send_frame(N, N - 1, 1'b1, 1'b0, pulses);
        chk("gap_valid", 32'(frame_valid), 32'd1);
        chk("gap_pulses", 32'(pulses), 32'd0);
        chk_l("gap_l", snap_l);
        ack_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
